// File: rtl/timer_ccp_pkg.sv
// Shared constants and types for the timer_ccp capture/compare/PWM timer:
// register map, config/ctrl field positions and the channel mode encoding.
package timer_ccp_pkg;

  localparam int MAX_WIDTH = 32;

  localparam logic [7:0] ADDR_CNT       = 8'h00;
  localparam logic [7:0] ADDR_RELOAD    = 8'h04;
  localparam logic [7:0] ADDR_CONFIG    = 8'h08;
  localparam logic [7:0] ADDR_STATUS    = 8'h09;
  localparam logic [7:0] ADDR_INTMASK   = 8'h0A;
  localparam logic [7:0] ADDR_CH_BASE   = 8'h10;
  localparam logic [7:0] ADDR_CH_STRIDE = 8'h08;
  localparam logic [7:0] CH_VALUE_OFS   = 8'h04;

  localparam int CFG_CLKSEL_LSB  = 0;
  localparam int CFG_PRESC_LSB   = 4;
  localparam int CFG_ONESHOT     = 7;

  localparam int CTRL_MODE_LSB   = 0;
  localparam int CTRL_CAPSEL_LSB = 2;
  localparam int CTRL_OVERRUN    = 7;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    COMPARE = 2'd1,
    CAPTURE = 2'd2,
    PWM     = 2'd3
  } mode_t;

  // Last prescaler value before wrap for a divide of 4^p; p >= 4 saturates at /256.
  function automatic logic [7:0] presc_last(input logic [2:0] p);
    case (p)
      3'd0:    return 8'd0;
      3'd1:    return 8'd3;
      3'd2:    return 8'd15;
      3'd3:    return 8'd63;
      default: return 8'd255;
    endcase
  endfunction

endpackage

// File: rtl/timer_ccp_channel.sv
// One timer_ccp channel: ctrl/value registers with compare, input capture and PWM.
// PWM hardware exists only when TIMER_CCP_PWM_EN is defined; otherwise mode 3 is inert.
module timer_ccp_channel
  import timer_ccp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CH    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       addr_i,
  input  logic             wr_i,
  input  logic [7:0]       wdata_i,
  input  logic [15:0]      edge_i,
  input  logic [WIDTH-1:0] counter_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] cnt_next_i,
  input  logic             flag_i,
  output logic             set_o,
  output logic             pwm_o,
  output logic [7:0]       rdata_o
);

  localparam logic [7:0] BASE   = ADDR_CH_BASE + 8'(CH * ADDR_CH_STRIDE);
  localparam int         NBYTES = WIDTH / 8;

  logic [7:0]           ctrl_q, ctrl_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic [MAX_WIDTH-1:0] val_ext;
  mode_t                mode;
  logic                 capture;

  always_comb begin
    mode    = mode_t'(ctrl_q[CTRL_MODE_LSB +: 2]);
    capture = (mode == CAPTURE) && edge_i[ctrl_q[CTRL_CAPSEL_LSB +: 4]];
    set_o   = capture || ((mode == COMPARE) && tick_i && (cnt_next_i == value_q));

    ctrl_d  = ctrl_q;
    value_d = value_q;
    if (wr_i && addr_i == BASE) ctrl_d = {2'b00, wdata_i[5:0]};
    if (capture && flag_i) ctrl_d[CTRL_OVERRUN] = 1'b1;
    for (int b = 0; b < NBYTES; b++) begin
      if (wr_i && addr_i == BASE + CH_VALUE_OFS + 8'(b)) value_d[8*b +: 8] = wdata_i;
    end
    // Capture overrides a software write to value in the same cycle.
    if (capture) value_d = counter_i;

    val_ext = '0;
    val_ext[WIDTH-1:0] = value_q;
    rdata_o = 8'd0;
    if (addr_i == BASE) rdata_o = ctrl_q;
    else if (addr_i[7:3] == BASE[7:3] && addr_i[2]) rdata_o = val_ext[{addr_i[1:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= 8'd0;
      value_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      value_q <= value_d;
    end
  end

`ifdef TIMER_CCP_PWM_EN
  logic pwm_q;
  always_ff @(posedge clk) begin
    if (reset) pwm_q <= 1'b0;
    else       pwm_q <= (mode == PWM) && (counter_i < value_q);
  end
  assign pwm_o = pwm_q;
`else
  assign pwm_o = 1'b0;
`endif

endmodule

// File: rtl/timer_ccp.sv
// timer_ccp: up-counter with reload, power-of-4 prescaler and NUM_CHANNELS capture/compare/PWM
// channels on a byte-wide register bus. PWM output enabled by defining TIMER_CCP_PWM_EN.
module timer_ccp
  import timer_ccp_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int NUM_INPUTS   = 1,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              addr,
  input  logic                    wr,
  input  logic [7:0]              wdata,
  output logic [7:0]              rdata,
  input  logic [NUM_INPUTS-1:0]   in,
  output logic [NUM_CHANNELS-1:0] pwm_out,
  output logic                    irq
);

  localparam int         NBYTES    = WIDTH / 8;
  localparam int         SW        = 1 + NUM_CHANNELS;
  localparam logic [7:0] STAT_MASK = 8'((1 << SW) - 1);

  logic [WIDTH-1:0]      counter_q, counter_d, reload_q, reload_d, cnt_next;
  logic [7:0]            config_q, config_d, status_q, status_d, intmask_q, presc_q, presc_d;
  logic [7:0]            set_vec;
  logic [NUM_INPUTS-1:0] in_q;
  logic                  irq_q;
  logic [15:0]           edge_ext;
  logic [3:0]            clksel;
  logic                  count_now, tick, tick_eff, cnt_wr, ovf;
  logic [NUM_CHANNELS-1:0] ch_set;
  logic [7:0]            ch_rdata [NUM_CHANNELS];
  logic [MAX_WIDTH-1:0]  cnt_ext, rel_ext;

  assign clksel = config_q[CFG_CLKSEL_LSB +: 4];

  // Edge vector padded to 16 so any 4-bit select beyond NUM_INPUTS sees 0.
  always_comb begin
    edge_ext = '0;
    edge_ext[NUM_INPUTS-1:0] = in & ~in_q;
    count_now = 1'b0;
    if (clksel == 4'd1)       count_now = 1'b1;
    else if (clksel >= 4'd2)  count_now = edge_ext[clksel - 4'd2];
    tick = count_now && (presc_q == 8'd0);
  end

  always_comb begin
    cnt_wr    = 1'b0;
    counter_d = counter_q;
    reload_d  = reload_q;
    for (int b = 0; b < NBYTES; b++) begin
      if (wr && addr == ADDR_CNT + 8'(b)) begin
        cnt_wr = 1'b1;
        counter_d[8*b +: 8] = wdata;
      end
      if (wr && addr == ADDR_RELOAD + 8'(b)) reload_d[8*b +: 8] = wdata;
    end
    // A software counter write owns the cycle: no tick, no overflow.
    tick_eff = tick && !cnt_wr;
    ovf      = tick_eff && (counter_q == '1);
    cnt_next = (counter_q == '1) ? reload_q : counter_q + WIDTH'(1);
    if (tick_eff) counter_d = cnt_next;
  end

  always_comb begin
    config_d = config_q;
    presc_d  = presc_q;
    if (count_now)
      presc_d = (presc_q == presc_last(config_q[CFG_PRESC_LSB +: 3])) ? 8'd0 : presc_q + 8'd1;
    if (ovf && config_q[CFG_ONESHOT]) config_d[CFG_CLKSEL_LSB +: 4] = 4'd0;
    if (wr && addr == ADDR_CONFIG) begin
      config_d = wdata;
      presc_d  = 8'd0;
    end

    set_vec = 8'd0;
    set_vec[SW-1:0] = {ch_set, ovf};
    status_d = status_q;
    if (wr && addr == ADDR_STATUS) status_d = status_q & ~wdata;
    status_d = (status_d | set_vec) & STAT_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      reload_q  <= '0;
      config_q  <= 8'd0;
      status_q  <= 8'd0;
      intmask_q <= 8'd0;
      presc_q   <= 8'd0;
      in_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      reload_q  <= reload_d;
      config_q  <= config_d;
      status_q  <= status_d;
      presc_q   <= presc_d;
      in_q      <= in;
      irq_q     <= |(status_q & intmask_q);
      if (wr && addr == ADDR_INTMASK) intmask_q <= wdata & STAT_MASK;
    end
  end

  assign irq = irq_q;

  for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_ch
    timer_ccp_channel #(
      .WIDTH (WIDTH),
      .CH    (n)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .addr_i     (addr),
      .wr_i       (wr),
      .wdata_i    (wdata),
      .edge_i     (edge_ext),
      .counter_i  (counter_q),
      .tick_i     (tick_eff),
      .cnt_next_i (cnt_next),
      .flag_i     (status_q[1+n]),
      .set_o      (ch_set[n]),
      .pwm_o      (pwm_out[n]),
      .rdata_o    (ch_rdata[n])
    );
  end

  always_comb begin
    cnt_ext = '0;
    cnt_ext[WIDTH-1:0] = counter_q;
    rel_ext = '0;
    rel_ext[WIDTH-1:0] = reload_q;
    rdata = 8'd0;
    if (addr[7:2] == 6'd0)          rdata = cnt_ext[{addr[1:0], 3'b000} +: 8];
    else if (addr[7:2] == 6'd1)     rdata = rel_ext[{addr[1:0], 3'b000} +: 8];
    else if (addr == ADDR_CONFIG)   rdata = config_q;
    else if (addr == ADDR_STATUS)   rdata = status_q;
    else if (addr == ADDR_INTMASK)  rdata = intmask_q;
    for (int n = 0; n < NUM_CHANNELS; n++) rdata = rdata | ch_rdata[n];
  end

endmodule

// File: tb/tb_timer_ccp.sv
// Directed self-checking bench for timer_ccp (WIDTH=16, one input, two channels).
// PWM expectations follow TIMER_CCP_PWM_EN as defined for the build.
module tb_timer_ccp;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic       wr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [0:0] in_sig;
  logic [1:0] pwm_out;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_ccp #(.WIDTH(16), .NUM_INPUTS(1), .NUM_CHANNELS(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wr      (wr),
    .wdata   (wdata),
    .rdata   (rdata),
    .in      (in_sig),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wreg(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    addr = a; wr = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic rd16(input logic [7:0] a, output logic [15:0] d);
    logic [7:0] lo, hi;
    rd(a, lo);
    rd(a + 8'd1, hi);
    d = {hi, lo};
  endtask

  task automatic w16(input logic [7:0] a, input logic [15:0] d);
    wreg(a, d[7:0]);
    wreg(a + 8'd1, d[15:8]);
  endtask

  task automatic test_reset;
    logic [7:0] addrs [8];
    logic [7:0] v;
    addrs = '{8'h00, 8'h01, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h10, 8'h14};
    reset = 1'b1; wr = 1'b0; addr = 8'h00; wdata = 8'h00; in_sig = 1'b0;
    cyc(3);
    reset = 1'b0;
    foreach (addrs[i]) begin
      rd(addrs[i], v);
      n_checks++;
      if (v !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg[%0h] got %0h want 00", addrs[i], v);
      end
    end
    n_checks++;
    if (pwm_out !== 2'b00 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs got pwm=%b irq=%b want pwm=00 irq=0", pwm_out, irq);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] c; logic [7:0] s;
    w16(8'h04, 16'hFFF0);
    w16(8'h00, 16'hFFFE);
    wreg(8'h0A, 8'h01);
    wreg(8'h08, 8'h01);
    cyc(1);
    rd16(8'h00, c);
    n_checks++;
    if (c !== 16'hFFFF) begin n_fail++; $display("FAIL ovf_first_inc got %h want FFFF", c); end
    cyc(1);
    rd16(8'h00, c); rd(8'h09, s);
    n_checks++;
    if (c !== 16'hFFF0 || s !== 8'h01 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_reload got cnt=%h st=%h irq=%b want FFF0 01 0", c, s, irq);
    end
    cyc(1);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ovf_irq got %b want 1", irq); end
    wreg(8'h08, 8'h00);
  endtask

  task automatic test_w1c_collision;
    logic [15:0] c; logic [7:0] s;
    wreg(8'h09, 8'hFF);
    rd(8'h09, s);
    n_checks++;
    if (s !== 8'h00) begin n_fail++; $display("FAIL w1c_clear got %h want 00", s); end
    w16(8'h00, 16'hFFFF);
    wreg(8'h08, 8'h01);
    wreg(8'h09, 8'h01);
    rd(8'h09, s); rd16(8'h00, c);
    n_checks++;
    if (s !== 8'h01 || c !== 16'hFFF0) begin
      n_fail++;
      $display("FAIL w1c_vs_set got st=%h cnt=%h want 01 FFF0", s, c);
    end
    wreg(8'h08, 8'h00);
  endtask

  task automatic test_cnt_write_collision;
    logic [15:0] c;
    w16(8'h00, 16'h1200);
    wreg(8'h08, 8'h01);
    cyc(1);
    rd16(8'h00, c);
    n_checks++;
    if (c !== 16'h1201) begin n_fail++; $display("FAIL cnt_run got %h want 1201", c); end
    wreg(8'h00, 8'h55);
    rd16(8'h00, c);
    n_checks++;
    if (c !== 16'h1255) begin n_fail++; $display("FAIL cnt_write_tick got %h want 1255", c); end
    wreg(8'h08, 8'h00);
    rd16(8'h00, c);
    n_checks++;
    if (c !== 16'h1256) begin n_fail++; $display("FAIL cnt_resume got %h want 1256", c); end
    wreg(8'h09, 8'hFF);
  endtask

  task automatic test_prescaler;
    logic [15:0] c;
    w16(8'h00, 16'h0000);
    wreg(8'h08, 8'h11);
    cyc(20);
    rd16(8'h00, c);
    n_checks++;
    if (c !== 16'h0005) begin n_fail++; $display("FAIL presc_div4 got %h want 0005", c); end
    cyc(2);
    wreg(8'h08, 8'h11);
    rd16(8'h00, c);
    n_checks++;
    if (c !== 16'h0006) begin n_fail++; $display("FAIL presc_rewrite got %h want 0006", c); end
    cyc(1);
    rd16(8'h00, c);
    n_checks++;
    if (c !== 16'h0007) begin n_fail++; $display("FAIL presc_phase_restart got %h want 0007", c); end
    wreg(8'h08, 8'h00);
  endtask

  task automatic test_capture;
    logic [15:0] v; logic [7:0] s, ct;
    wreg(8'h09, 8'hFF);
    wreg(8'h10, 8'h02);
    w16(8'h00, 16'h0120);
    wreg(8'h08, 8'h01);
    cyc(3);
    in_sig = 1'b1;
    cyc(1);
    in_sig = 1'b0;
    rd16(8'h14, v); rd(8'h09, s); rd(8'h10, ct);
    n_checks++;
    if (v !== 16'h0123 || s !== 8'h02 || ct !== 8'h02) begin
      n_fail++;
      $display("FAIL capture got val=%h st=%h ctrl=%h want 0123 02 02", v, s, ct);
    end
    cyc(1);
    in_sig = 1'b1;
    cyc(1);
    in_sig = 1'b0;
    rd16(8'h14, v); rd(8'h10, ct);
    n_checks++;
    if (v !== 16'h0125 || ct !== 8'h82) begin
      n_fail++;
      $display("FAIL capture_overrun got val=%h ctrl=%h want 0125 82", v, ct);
    end
    wreg(8'h10, 8'h02);
    rd(8'h10, ct);
    n_checks++;
    if (ct !== 8'h02) begin n_fail++; $display("FAIL overrun_clear got %h want 02", ct); end
    wreg(8'h08, 8'h00);
    wreg(8'h10, 8'h00);
  endtask

  task automatic test_compare_oneshot;
    logic [15:0] c; logic [7:0] s, cf;
    wreg(8'h09, 8'hFF);
    wreg(8'h18, 8'h01);
    w16(8'h1C, 16'h0010);
    w16(8'h00, 16'h000C);
    wreg(8'h08, 8'h81);
    cyc(3);
    rd(8'h09, s);
    n_checks++;
    if (s !== 8'h00) begin n_fail++; $display("FAIL cmp_early got %h want 00", s); end
    cyc(1);
    rd(8'h09, s);
    n_checks++;
    if (s !== 8'h04) begin n_fail++; $display("FAIL cmp_hit got %h want 04", s); end
    wreg(8'h01, 8'hFF);
    wreg(8'h00, 8'hFE);
    cyc(5);
    rd16(8'h00, c); rd(8'h08, cf); rd(8'h09, s);
    n_checks++;
    if (c !== 16'hFFF0 || cf !== 8'h80 || s !== 8'h05) begin
      n_fail++;
      $display("FAIL oneshot got cnt=%h cfg=%h st=%h want FFF0 80 05", c, cf, s);
    end
    wreg(8'h18, 8'h00);
    wreg(8'h09, 8'hFF);
  endtask

  task automatic test_pwm;
    int hi0, hi1;
    int exp_hi;
`ifdef TIMER_CCP_PWM_EN
    exp_hi = 64;
`else
    exp_hi = 0;
`endif
    w16(8'h04, 16'hFF00);
    w16(8'h14, 16'hFF40);
    wreg(8'h10, 8'h03);
    w16(8'h00, 16'hFF00);
    wreg(8'h08, 8'h01);
    cyc(3);
    hi0 = 0; hi1 = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      if (pwm_out[0] === 1'b1) hi0++;
      if (pwm_out[1] !== 1'b0) hi1++;
    end
    n_checks++;
    if (hi0 != exp_hi) begin n_fail++; $display("FAIL pwm_duty got %0d want %0d", hi0, exp_hi); end
    n_checks++;
    if (hi1 != 0) begin n_fail++; $display("FAIL pwm_off_ch got %0d want 0", hi1); end
    w16(8'h14, 16'h0000);
    cyc(2);
    hi0 = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      if (pwm_out[0] !== 1'b0) hi0++;
    end
    n_checks++;
    if (hi0 != 0) begin n_fail++; $display("FAIL pwm_zero got %0d want 0", hi0); end
    wreg(8'h08, 8'h00);
    wreg(8'h10, 8'h00);
  endtask

  task automatic test_midcount_reset;
    logic [15:0] c; logic [7:0] cf;
    wreg(8'h08, 8'h01);
    cyc(5);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    rd16(8'h00, c); rd(8'h08, cf);
    n_checks++;
    if (c !== 16'h0000 || cf !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset got cnt=%h cfg=%h want 0000 00", c, cf);
    end
    cyc(4);
    rd16(8'h00, c);
    n_checks++;
    if (c !== 16'h0000) begin n_fail++; $display("FAIL midreset_hold got %h want 0000", c); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_w1c_collision();
    test_cnt_write_collision();
    test_prescaler();
    test_capture();
    test_compare_oneshot();
    test_pwm();
    test_midcount_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
